// File: rtl/alarm_pkg.sv
// alarm_pkg: note half-periods, per-source alarm phrases and scheduler states
package alarm_pkg;
    localparam logic [16:0] HP_DO   = 17'd47778;
    localparam logic [16:0] HP_RE   = 17'd42566;
    localparam logic [16:0] HP_MI   = 17'd37922;
    localparam logic [16:0] HP_FA   = 17'd35793;
    localparam logic [16:0] HP_SI   = 17'd50619;
    localparam logic [16:0] HP_REST = 17'd0;

    localparam int N_NOTES = 4;

    // One row per requester, index 0 is the highest-priority source
    localparam logic [16:0] PATTERN [4][N_NOTES] = '{
        '{HP_MI, HP_SI, HP_DO,   HP_FA},
        '{HP_RE, HP_MI, HP_RE,   HP_MI},
        '{HP_FA, HP_FA, HP_REST, HP_FA},
        '{HP_SI, HP_DO, HP_SI,   HP_REST}
    };

    typedef enum logic [1:0] {IDLE, ARB, PLAY, GAP} state_t;
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave that toggles every half_period cycles; half_period 0 is silence
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [16:0] half_period,
    output logic        tone
);
    logic [16:0] r_cnt;
    logic        r_tone;

    always_ff @(posedge clk) begin
        if (rst || restart || half_period == '0) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (r_cnt == half_period - 17'd1) begin
            r_cnt  <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_cnt <= r_cnt + 17'd1;
        end
    end

    assign tone = r_tone;
endmodule

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: fixed-priority, non-preemptive sharing of one buzzer between alarm sources,
// each winner plays its 4-note phrase through tone_gen
module alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int NOTE_TICKS = 10_000_000,
    parameter int GAP_TICKS  = 2_500_000,
    parameter int HP_SHIFT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mute,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic [1:0]       note_idx,
    output logic             melody
);
    localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

    state_t           r_state, w_state;
    logic [N_REQ-1:0] r_grant, w_grant;
    logic [1:0]       r_note, w_note;
    logic [1:0]       r_owner, w_owner;
    logic [31:0]      r_cnt, w_cnt;
    logic [1:0]       w_idx;
    logic [N_REQ-1:0] w_onehot;
    logic [16:0]      w_hp;
    logic             w_drop, w_note_end, w_gap_end, w_tone;

    always_comb begin
        w_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[i]) w_idx = 2'(i);
    end

    assign w_onehot   = N_REQ'(1) << w_idx;
    assign w_drop     = (req & r_grant) == '0;
    assign w_note_end = r_cnt == NOTE_LAST;
    assign w_gap_end  = r_cnt == GAP_LAST;
    assign w_hp       = PATTERN[r_owner][r_note] >> HP_SHIFT;

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_note  = r_note;
        w_owner = r_owner;
        w_cnt   = '0;
        case (r_state)
            IDLE: w_state = |req ? ARB : IDLE;
            ARB: begin
                w_state = |req ? PLAY : IDLE;
                w_grant = w_onehot;
                w_owner = w_idx;
                w_note  = '0;
            end
            PLAY: begin
                w_state = w_drop ? IDLE : w_note_end ? GAP : PLAY;
                w_cnt   = (w_drop || w_note_end) ? '0 : r_cnt + 32'd1;
            end
            GAP: begin
                w_state = w_drop ? IDLE : !w_gap_end ? GAP : r_note == 2'd3 ? ARB : PLAY;
                w_cnt   = (w_drop || w_gap_end) ? '0 : r_cnt + 32'd1;
                w_note  = (w_gap_end && r_note != 2'd3) ? r_note + 2'd1 : r_note;
            end
            default: w_state = IDLE;
        endcase
        // Anything that lands in IDLE releases the buzzer and abandons the phrase
        if (w_state == IDLE) begin
            w_grant = '0;
            w_note  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_note  <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_note  <= w_note;
            r_owner <= w_owner;
            r_cnt   <= w_cnt;
        end
    end

    // Holding the tone in restart outside PLAY makes every note start from a clean low phase
    tone_gen u_tone (
        .clk        (clk),
        .rst        (rst),
        .restart    (r_state != PLAY),
        .half_period(w_hp),
        .tone       (w_tone)
    );

    assign grant    = r_grant;
    assign busy     = r_state != IDLE;
    assign note_idx = r_note;
    assign melody   = w_tone & ~mute & (r_state == PLAY);
endmodule

// File: tb/tb_alarm_scheduler.sv
// tb_alarm_scheduler: expected per-cycle outputs are queued as stimulus is planned,
// and popped against the DUT on every falling edge
module tb_alarm_scheduler;
    localparam int NOTE  = 20;
    localparam int GAP   = 4;
    localparam int SHIFT = 12;
    localparam int DO = 47778 >> SHIFT;
    localparam int RE = 42566 >> SHIFT;
    localparam int MI = 37922 >> SHIFT;
    localparam int FA = 35793 >> SHIFT;
    localparam int SI = 50619 >> SHIFT;
    localparam int PAT [4][4] = '{
        '{MI, SI, DO, FA},
        '{RE, MI, RE, MI},
        '{FA, FA, 0,  FA},
        '{SI, DO, SI, 0}
    };

    typedef struct {
        logic [3:0] grant;
        logic [1:0] note;
        logic       busy;
        logic       mel;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    fails  = 0;
    string scn    = "init";

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mute = 1'b0;
    logic [3:0] req  = '0;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] note_idx;
    logic       melody;

    alarm_scheduler #(
        .N_REQ     (4),
        .NOTE_TICKS(NOTE),
        .GAP_TICKS (GAP),
        .HP_SHIFT  (SHIFT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mute    (mute),
        .grant   (grant),
        .busy    (busy),
        .note_idx(note_idx),
        .melody  (melody)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s/%s got=%0h exp=%0h", scn, tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("grant", 32'(grant), 32'(e.grant));
            check("note", 32'(note_idx), 32'(e.note));
            check("busy", 32'(busy), 32'(e.busy));
            check("melody", 32'(melody), 32'(e.mel));
        end
    end

    task automatic push(input logic [3:0] g, input logic [1:0] n, input logic b, input logic m);
        exp_t e;
        e.grant = g;
        e.note  = n;
        e.busy  = b;
        e.mel   = m;
        q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(4'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // Tone is low for the first hp cycles of a note, then alternates every hp cycles
    task automatic push_note(input logic [3:0] g, input int n, input int hp, input bit muted,
                             input int plays, input int gaps);
        for (int k = 0; k < plays; k++)
            push(g, 2'(n), 1'b1, (hp == 0 || muted) ? 1'b0 : 1'((k / hp) % 2));
        repeat (gaps) push(g, 2'(n), 1'b1, 1'b0);
    endtask

    task automatic push_phrase(input int o, input bit muted);
        for (int n = 0; n < 4; n++) push_note(4'(1 << o), n, PAT[o][n], muted, NOTE, GAP);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
        q.delete();
        cyc(1);
    endtask

    initial begin
        cyc(2);
        scn = "reset";
        push_idle(3);
        req = 4'hF;
        cyc(3);
        rst = 1'b0;
        req = '0;
        drain();

        scn = "req0";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_phrase(0, 1'b0);
        push(4'b0001, 2'd3, 1'b1, 1'b0);
        push_idle(2);
        req = 4'b0001;
        cyc(98);
        req = '0;
        drain();

        scn = "req1";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_phrase(1, 1'b0);
        push(4'b0010, 2'd3, 1'b1, 1'b0);
        push(4'b0010, 2'd0, 1'b1, 1'b0);
        push_idle(2);
        req = 4'b1010;
        cyc(99);
        req = '0;
        drain();

        scn = "nopreempt";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_phrase(3, 1'b0);
        push(4'b1000, 2'd3, 1'b1, 1'b0);
        push(4'b0001, 2'd0, 1'b1, 1'b0);
        push_idle(2);
        req = 4'b1000;
        cyc(27);
        req = 4'b1001;
        cyc(72);
        req = '0;
        drain();

        scn = "drop";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_note(4'b0001, 0, MI, 1'b0, NOTE, GAP);
        push_note(4'b0001, 1, SI, 1'b0, NOTE, GAP);
        push_note(4'b0001, 2, DO, 1'b0, 16, 0);
        push_idle(2);
        req = 4'b0001;
        cyc(65);
        req = '0;
        drain();

        scn = "rest";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_phrase(2, 1'b0);
        push(4'b0100, 2'd3, 1'b1, 1'b0);
        push_idle(2);
        req = 4'b0100;
        cyc(98);
        req = '0;
        drain();

        scn = "mute";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_phrase(0, 1'b1);
        push(4'b0001, 2'd3, 1'b1, 1'b0);
        push_idle(2);
        req  = 4'b0001;
        mute = 1'b1;
        cyc(98);
        req = '0;
        drain();
        mute = 1'b0;

        scn = "midrst";
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_note(4'b0010, 0, RE, 1'b0, NOTE, GAP);
        push_note(4'b0010, 1, MI, 1'b0, 15, 0);
        push_idle(1);
        push(4'd0, 2'd0, 1'b1, 1'b0);
        push_idle(2);
        req = 4'b0010;
        cyc(40);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        req = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
